// File: rtl/relay_symbol_fifo_if.sv
// relay_symbol_fifo_if
//   Bundles the symbol path between relay_decode, the elastic buffer and
//   relay_mode.
//   master : producer/observer side (drives in_*, watches out_* and status)
//   slave  : buffer side (consumes in_*, drives out_* and status)
//   Signals:
//     in_data[3:0]  decoded symbol,  in_valid  one-cycle strobe qualifying it
//     out_data[3:0] paced symbol,    out_valid one-cycle pulse per pop
//     level         stored entries (0..DEPTH)
//     overflow      sticky, a write was dropped
//     underrun      sticky, a pace tick found the buffer empty
interface relay_symbol_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [3:0]    in_data;
  logic          in_valid;
  logic [3:0]    out_data;
  logic          out_valid;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underrun;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, level, overflow, underrun
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, level, overflow, underrun
  );
endinterface

// File: rtl/relay_symbol_fifo.sv
// relay_symbol_fifo
//   Elastic buffer between relay_decode and relay_mode. Symbols arrive at an
//   irregular rate; once PREFILL symbols are stored they are replayed one
//   every PACE clocks so relay_mode sees an evenly spaced stream.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-low, clears all state
//     enable : relay active; low flushes the buffer and idles the block
//     bus    : relay_symbol_fifo_if.slave (in_*, out_*, level, flags)
module relay_symbol_fifo #(
  parameter int DEPTH   = 16,
  parameter int PACE    = 16,
  parameter int PREFILL = 4
) (
  input logic                clk,
  input logic                reset,
  input logic                enable,
  relay_symbol_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(PACE);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [PW-1:0] PACE_LAST = PW'(PACE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] pacer_q, pacer_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic          underrun_q, underrun_d;
  logic [3:0]    out_data_q;
  logic          push, pop;

  logic [3:0] mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    pacer_d     = pacer_q;
    overflow_d  = overflow_q;
    underrun_d  = underrun_q;
    out_valid_d = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    if (!enable) begin
      // Flush: everything returns to its idle value, sticky flags included.
      state_d    = S_IDLE;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      pacer_d    = '0;
      overflow_d = 1'b0;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FILL;
        S_FILL: begin
          if (level_q >= PREFILL_L) begin
            state_d = S_STREAM;
            pacer_d = '0;
          end
        end
        S_STREAM: begin
          if (pacer_q == PACE_LAST) begin
            pacer_d = '0;
            // Pop decision uses the pre-push level: a symbol arriving on an
            // empty tick is stored, not forwarded.
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = S_FILL;
            end
          end else begin
            pacer_d = pacer_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A pop frees a slot this cycle, so a full buffer can still accept.
      if (state_q != S_IDLE && bus.in_valid) begin
        if (level_q != DEPTH_L || pop) begin
          push = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end

      if (pop) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_valid_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      pacer_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      pacer_q     <= pacer_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  // Registered read; on a full-boundary push+pop the read sees the old
  // entry before the write lands in the same slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data_q <= 4'h0;
    end else if (pop) begin
      out_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_relay_symbol_fifo.sv
// tb_relay_symbol_fifo
//   Directed bench for relay_symbol_fifo (DEPTH=16, PACE=16, PREFILL=4):
//   a per-cycle vector table for reset/enable/fill behaviour, then
//   hand-written sequences for streaming, overflow, full-boundary push+pop,
//   pointer wrap, enable drop and mid-stream reset.
module tb_relay_symbol_fifo;
  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  relay_symbol_fifo_if #(.DEPTH(16)) bus ();

  relay_symbol_fifo #(.DEPTH(16), .PACE(16), .PREFILL(4)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .enable (en),
    .bus    (bus)
  );

  typedef struct {
    logic       rn;
    logic       e;
    logic       v;
    logic [3:0] d;
    logic       ov;
    logic [3:0] od;
    int         lvl;
    logic       ovf;
    logic       und;
  } vec_t;

  vec_t tbl [12];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  int   pop_d [$];
  int   pop_t [$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, step one edge, sample 1ns later, log pops.
  task automatic cyc(input logic e, input logic v, input logic [3:0] d);
    en           = e;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus.out_valid) begin
      pop_d.push_back(int'(bus.out_data));
      pop_t.push_back(cyc_n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;
    pop_d.delete();
    pop_t.delete();
  endtask

  initial begin
    int t4, und_t, maxl, minl, bad_order, found;
    rst_n        = 1'b0;
    en           = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;

    // rn e v d | ov od lvl ovf und
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0, 1'b0}; // reset
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 0, 1'b0, 1'b0}; // push in IDLE ignored
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0, 2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 3, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 4'h0, 4, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4, 1'b0, 1'b0}; // enters STREAM
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0, 1'b0}; // flush
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 0, 1'b0, 1'b0}; // IDLE again
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 4'h0, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 4'h0, 0, 1'b0, 1'b0}; // reset wins
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rn;
      cyc(tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d.out_valid", i), int'(bus.out_valid), int'(tbl[i].ov));
      chk($sformatf("vec%0d.out_data", i),  int'(bus.out_data),  int'(tbl[i].od));
      chk($sformatf("vec%0d.level", i),     int'(bus.level),     tbl[i].lvl);
      chk($sformatf("vec%0d.overflow", i),  int'(bus.overflow),  int'(tbl[i].ovf));
      chk($sformatf("vec%0d.underrun", i),  int'(bus.underrun),  int'(tbl[i].und));
    end

    // Basic stream: 8 symbols, pops 16 apart, underrun on the 9th tick.
    do_reset();
    cyc(1'b1, 1'b0, 4'h0);
    maxl = 0;
    t4   = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b1, 4'(k));
      if (k == 4) t4 = cyc_n;
      if (int'(bus.level) > maxl) maxl = int'(bus.level);
    end
    und_t = -1;
    repeat (170) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (int'(bus.level) > maxl) maxl = int'(bus.level);
      if (bus.underrun && und_t < 0) und_t = cyc_n;
    end
    chk("basic.pop_count", pop_d.size(), 8);
    for (int i = 0; i < pop_d.size() && i < 8; i++) begin
      chk($sformatf("basic.data%0d", i), pop_d[i], i + 1);
      chk($sformatf("basic.time%0d", i), pop_t[i], t4 + 17 + 16 * i);
    end
    chk("basic.level_peak", maxl, 8);
    chk("basic.level_end", int'(bus.level), 0);
    chk("basic.underrun_time", und_t, t4 + 17 + 128);

    // Overflow: 20 back-to-back pushes, last 4 dropped.
    do_reset();
    cyc(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 4'(i));
    chk("ovf.level_full", int'(bus.level), 16);
    chk("ovf.flag", int'(bus.overflow), 1);
    chk("ovf.no_early_pop", pop_d.size(), 0);
    repeat (282) cyc(1'b1, 1'b0, 4'h0);
    chk("ovf.pop_count", pop_d.size(), 16);
    bad_order = 0;
    for (int i = 0; i < pop_d.size(); i++) if (pop_d[i] != (i % 16)) bad_order++;
    chk("ovf.order", bad_order, 0);
    chk("ovf.flag_sticky", int'(bus.overflow), 1);
    chk("ovf.underrun", int'(bus.underrun), 1);

    // Enable drop with level 6, flags set from the previous sequence.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 4'(i + 3));
    chk("endrop.level_before", int'(bus.level), 6);
    cyc(1'b0, 1'b0, 4'h0);
    chk("endrop.level", int'(bus.level), 0);
    chk("endrop.overflow", int'(bus.overflow), 0);
    chk("endrop.underrun", int'(bus.underrun), 0);
    pop_d.delete();
    pop_t.delete();
    repeat (5) cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'(i + 9));
    repeat (40) cyc(1'b1, 1'b0, 4'h0);
    chk("endrop.no_output_before_prefill", pop_d.size(), 0);
    chk("endrop.level_partial", int'(bus.level), 3);
    cyc(1'b1, 1'b1, 4'hC);
    t4 = cyc_n;
    repeat (20) cyc(1'b1, 1'b0, 4'h0);
    chk("endrop.repop_count", pop_d.size(), 1);
    if (pop_d.size() > 0) begin
      chk("endrop.repop_time", pop_t[0], t4 + 17);
      chk("endrop.repop_data", pop_d[0], 9);
    end

    // Full-boundary push on the exact tick cycle.
    do_reset();
    cyc(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'(i));
    chk("full.level16", int'(bus.level), 16);
    repeat (4) cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'hA);
    chk("full.tick_pop", int'(bus.out_valid), 1);
    chk("full.level_kept", int'(bus.level), 16);
    chk("full.no_overflow", int'(bus.overflow), 0);
    repeat (272) cyc(1'b1, 1'b0, 4'h0);
    chk("full.pop_count", pop_d.size(), 17);
    bad_order = 0;
    for (int i = 0; i < pop_d.size() && i < 16; i++) if (pop_d[i] != i) bad_order++;
    chk("full.order", bad_order, 0);
    if (pop_d.size() > 16) chk("full.last_is_A", pop_d[16], 10);

    // Pointer wrap: 100 symbols at one per PACE.
    do_reset();
    cyc(1'b1, 1'b0, 4'h0);
    minl = 99;
    maxl = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, 4'(i));
      if (i >= 3) begin
        if (int'(bus.level) < minl) minl = int'(bus.level);
        if (int'(bus.level) > maxl) maxl = int'(bus.level);
      end
      repeat (15) begin
        cyc(1'b1, 1'b0, 4'h0);
        if (i >= 3) begin
          if (int'(bus.level) < minl) minl = int'(bus.level);
          if (int'(bus.level) > maxl) maxl = int'(bus.level);
        end
      end
    end
    chk("wrap.level_in_3_5", int'(minl >= 3 && maxl <= 5), 1);
    chk("wrap.overflow", int'(bus.overflow), 0);
    chk("wrap.underrun", int'(bus.underrun), 0);
    repeat (100) cyc(1'b1, 1'b0, 4'h0);
    chk("wrap.pop_count", pop_d.size(), 100);
    bad_order = 0;
    for (int i = 0; i < pop_d.size(); i++) if (pop_d[i] != (i % 16)) bad_order++;
    chk("wrap.order", bad_order, 0);

    // Reset mid-stream at level 5 with overflow set.
    do_reset();
    cyc(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 4'(i));
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      cyc(1'b1, 1'b0, 4'h0);
      if (int'(bus.level) == 5) found = 1;
    end
    chk("rst.reached_level5", found, 1);
    chk("rst.overflow_before", int'(bus.overflow), 1);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 4'h0);
    rst_n = 1'b1;
    chk("rst.out_data", int'(bus.out_data), 0);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.level", int'(bus.level), 0);
    chk("rst.overflow", int'(bus.overflow), 0);
    chk("rst.underrun", int'(bus.underrun), 0);
    pop_d.delete();
    pop_t.delete();
    repeat (40) cyc(1'b1, 1'b0, 4'h0);
    chk("rst.no_output_after", pop_d.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
